ok_wire_or_pipe: RTL and testbench
==================================

# ok_wire_or_pipe

Parametrised, pipelined successor to the FrontPanel endpoint wire-OR collector. Merges N endpoint-to-host buses (okEHx) into the single okEH bus fed to the host core, using a registered OR-reduction tree so large endpoint counts close timing at okClk. Adds a per-endpoint enable mask and bus-contention detection: a sticky error flag and a saturating counter for cycles where two or more enabled endpoints drive non-zero words. Sits between the endpoint instances and okHost.

## Interface
- N, 4, number of endpoint buses merged (≥1)
- W, 65, width of each endpoint bus
- FANIN, 4, inputs OR-ed per tree node per stage (≥2)
- CNT_W, 16, width of the contention counter
- okClk  input  1  host interface clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- okEHx  input  N*W  endpoint buses, endpoint i at [i*W +: W]
- en_mask  input  N  bit i = 1 includes endpoint i; 0 forces its word to zero
- clr_err  input  1  single-cycle clear of collision_sticky and collision_count
- okEH  output  W  merged bus, registered
- collision  output  1  pulse, aligned with the okEH word in which contention occurred
- collision_sticky  output  1  set by any collision, held until clr_err or reset
- collision_count  output  CNT_W  saturating count of collision cycles

## Operation
- Masking is combinational ahead of stage 1: word_i = okEHx[i] & {W{en_mask[i]}}.
- Stage 1 reduces N words in groups of FANIN; each further stage reduces the previous stage's outputs the same way until one word remains. Missing inputs in a partial group are zero.
- Each tree node carries, besides its W-bit OR, two flags: any (some child non-zero) and multi (some child multi, or ≥2 children any). Leaf any = |word_i; leaf multi = 0.
- Root OR drives okEH; root multi drives collision.
- Sticky/counter update, evaluated each cycle after the root register:
  - clr_err = 1: sticky ← collision, count ← collision ? 1 : 0 (new event is not lost).
  - else on collision: sticky ← 1, count ← count+1, held at 2^CNT_W−1 (no wrap).
- N = 1: single register stage; collision is constant 0.
- okEH is a pure function of the inputs L cycles earlier; no back-pressure, no data storage beyond the pipeline.

## Timing
- Latency L = max(1, ceil(log_FANIN(N))) cycles from okEHx/en_mask to okEH and collision. Examples: N=4,F=4: L=1; N=5,F=4: L=2; N=16,F=4: L=2; N=17,F=4: L=3.
- Throughput one word per cycle.
- collision_sticky and collision_count change one cycle after the collision pulse.
- Reset (synchronous, any time, including mid-stream): on the cycle after reset is sampled high, all pipeline registers, okEH, collision, collision_sticky and collision_count are 0. Data in flight is discarded. The first valid okEH appears L cycles after the first non-reset input cycle.
- en_mask changes take effect on the word sampled in the same cycle, with no partial masking.

## Structure
- Package ok_wire_pkg:
  - function clog_fanin(n, f) returning the stage count L;
  - function stage_width(n, f, s) returning the node count at stage s;
  - default parameter constants.
- Sub-module ok_or_stage: one registered reduction level, parameters IN_CNT, FANIN, W; ports carry words plus any/multi vectors. The top instantiates L of them with a generate loop and adds mask logic and error bookkeeping.

## Test plan
- N=4, F=4, all enabled; endpoint 2 drives 0x1_0000_00AB, others 0 → okEH = 0x1_0000_00AB after 1 cycle, collision 0.
- N=16, F=4; endpoints 3 and 12 both non-zero in one cycle → collision pulse at cycle 2, sticky = 1 and count = 1 at cycle 3. okEH = OR of both words.
- Same as above with en_mask[12] = 0 → okEH = endpoint 3 word only, no collision.
- 70000 consecutive collision cycles with CNT_W=16 → count saturates at 0xFFFF. Then clr_err coincident with a collision → count = 1, sticky = 1.
- N=17, F=4: random single-driver traffic compared against a 3-cycle-delayed reference OR; reset asserted mid-stream → all outputs 0 next cycle, resumes with correct 3-cycle latency.
- N=1 → okEH follows masked input with 1-cycle latency; collision never asserts.

Source files
------------

// File: rtl/ok_wire_pkg.sv
// Shared sizing helpers and default parameters for the pipelined endpoint wire-OR collector.
package ok_wire_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_W     = 65;
    localparam int unsigned DEF_FANIN = 4;
    localparam int unsigned DEF_CNT_W = 16;

    // Number of reduction stages: max(1, ceil(log_f(n))).
    function automatic int unsigned clog_fanin(input int unsigned n, input int unsigned f);
        int unsigned l;
        int unsigned c;
        l = 0;
        c = 1;
        while (c < n) begin
            c = c * f;
            l = l + 1;
        end
        return (l == 0) ? 1 : l;
    endfunction

    // Node count after s reductions; stage 0 is the leaf count.
    function automatic int unsigned stage_width(input int unsigned n, input int unsigned f,
                                                input int unsigned s);
        int unsigned w;
        w = n;
        for (int unsigned i = 0; i < s; i++) begin
            w = (w + f - 1) / f;
        end
        return w;
    endfunction

endpackage

// File: rtl/ok_wire_or_pipe_stage.sv
// One registered OR-reduction level: groups of FANIN nodes collapse into one node
// carrying the OR word plus any/multi contention flags.
module ok_or_stage
    import ok_wire_pkg::*;
#(
    parameter  int unsigned IN_CNT  = 4,
    parameter  int unsigned FANIN   = 4,
    parameter  int unsigned W       = 65,
    localparam int unsigned OUT_CNT = (IN_CNT + FANIN - 1) / FANIN
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [IN_CNT*W-1:0]    word_i,
    input  logic [IN_CNT-1:0]      any_i,
    input  logic [IN_CNT-1:0]      multi_i,
    output logic [OUT_CNT*W-1:0]   word_o,
    output logic [OUT_CNT-1:0]     any_o,
    output logic [OUT_CNT-1:0]     multi_o
);

    localparam int unsigned PAD_CNT = OUT_CNT * FANIN;

    logic [PAD_CNT-1:0][W-1:0] word_pad;
    logic [PAD_CNT-1:0]        any_pad;
    logic [PAD_CNT-1:0]        multi_pad;

    logic [OUT_CNT-1:0][W-1:0] word_d, word_q;
    logic [OUT_CNT-1:0]        any_d, any_q;
    logic [OUT_CNT-1:0]        multi_d, multi_q;

    // A partial last group is padded with idle (zero) children.
    for (genvar j = 0; j < PAD_CNT; j++) begin : g_pad
        if (j < IN_CNT) begin : g_in
            assign word_pad[j]  = word_i[j*W +: W];
            assign any_pad[j]   = any_i[j];
            assign multi_pad[j] = multi_i[j];
        end else begin : g_zero
            assign word_pad[j]  = '0;
            assign any_pad[j]   = 1'b0;
            assign multi_pad[j] = 1'b0;
        end
    end

    always_comb begin
        word_d  = '0;
        any_d   = '0;
        multi_d = '0;
        for (int unsigned g = 0; g < OUT_CNT; g++) begin
            for (int unsigned k = 0; k < FANIN; k++) begin
                word_d[g]  = word_d[g] | word_pad[g*FANIN + k];
                multi_d[g] = multi_d[g] | multi_pad[g*FANIN + k]
                           | (any_d[g] & any_pad[g*FANIN + k]);
                any_d[g]   = any_d[g] | any_pad[g*FANIN + k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            any_q   <= '0;
            multi_q <= '0;
        end else begin
            word_q  <= word_d;
            any_q   <= any_d;
            multi_q <= multi_d;
        end
    end

    assign word_o  = word_q;
    assign any_o   = any_q;
    assign multi_o = multi_q;

endmodule

// File: rtl/ok_wire_or_pipe.sv
// Pipelined wire-OR of N endpoint buses into okEH, with per-endpoint enable mask
// and sticky/counting detection of cycles where two or more endpoints drive at once.
module ok_wire_or_pipe
    import ok_wire_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned FANIN = DEF_FANIN,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic               okClk,
    input  logic               reset,
    input  logic [N*W-1:0]     okEHx,
    input  logic [N-1:0]       en_mask,
    input  logic               clr_err,
    output logic [W-1:0]       okEH,
    output logic               collision,
    output logic               collision_sticky,
    output logic [CNT_W-1:0]   collision_count
);

    localparam int unsigned L = clog_fanin(N, FANIN);

    logic [N*W-1:0] leaf_word;
    logic [N-1:0]   leaf_any;

    always_comb begin
        leaf_word = '0;
        leaf_any  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            leaf_word[i*W +: W] = okEHx[i*W +: W] & {W{en_mask[i]}};
            leaf_any[i]         = |(okEHx[i*W +: W] & {W{en_mask[i]}});
        end
    end

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int unsigned IN_CNT  = stage_width(N, FANIN, s);
        localparam int unsigned OUT_CNT = stage_width(N, FANIN, s + 1);

        logic [IN_CNT*W-1:0]  in_word;
        logic [IN_CNT-1:0]    in_any;
        logic [IN_CNT-1:0]    in_multi;
        logic [OUT_CNT*W-1:0] out_word;
        logic [OUT_CNT-1:0]   out_any;
        logic [OUT_CNT-1:0]   out_multi;

        if (s == 0) begin : g_leaf
            assign in_word  = leaf_word;
            assign in_any   = leaf_any;
            assign in_multi = '0;
        end else begin : g_inner
            assign in_word  = g_stage[s-1].out_word;
            assign in_any   = g_stage[s-1].out_any;
            assign in_multi = g_stage[s-1].out_multi;
        end

        ok_or_stage #(
            .IN_CNT (IN_CNT),
            .FANIN  (FANIN),
            .W      (W)
        ) u_stage (
            .clk_i   (okClk),
            .rst_i   (reset),
            .word_i  (in_word),
            .any_i   (in_any),
            .multi_i (in_multi),
            .word_o  (out_word),
            .any_o   (out_any),
            .multi_o (out_multi)
        );
    end

    // Root multi always implies root any; the AND just consumes the root any flop.
    assign okEH      = g_stage[L-1].out_word;
    assign collision = g_stage[L-1].out_multi & g_stage[L-1].out_any;

    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] count_d, count_q;

    // A clear coincident with a collision keeps that new event.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_err) begin
            sticky_d = collision;
            count_d  = collision ? CNT_W'(1) : '0;
        end else if (collision) begin
            sticky_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign collision_sticky = sticky_q;
    assign collision_count  = count_q;

endmodule

// File: tb/tb_ok_wire_or_pipe.sv
// Randomized bench for ok_wire_or_pipe: four configurations run in lockstep,
// each checked every cycle against a delay-line reference of the merged bus.
module tb_ok_wire_or_pipe;

    localparam int unsigned W     = 65;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LANES = 4;

    function automatic int unsigned lane_n(input int unsigned i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 16;
            default: return 17;
        endcase
    endfunction

    // Expected latency with FANIN = 4, taken directly from the latency formula.
    function automatic int unsigned lane_l(input int unsigned i);
        case (i)
            0:       return 1;
            1:       return 1;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_word(output logic [W-1:0] w);
        w = W'({$urandom(), $urandom(), $urandom()});
    endtask

    for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
        localparam int unsigned LN_N = lane_n(ln);
        localparam int unsigned LN_L = lane_l(ln);

        logic [LN_N*W-1:0] ehx;
        logic [LN_N-1:0]   mask;
        logic              clr;
        logic              rst;
        logic [W-1:0]      eh;
        logic              coll;
        logic              sticky;
        logic [CNT_W-1:0]  cnt;
        bit                done = 1'b0;

        ok_wire_or_pipe #(
            .N     (LN_N),
            .W     (W),
            .FANIN (4),
            .CNT_W (CNT_W)
        ) u_dut (
            .okClk            (clk),
            .reset            (rst),
            .okEHx            (ehx),
            .en_mask          (mask),
            .clr_err          (clr),
            .okEH             (eh),
            .collision        (coll),
            .collision_sticky (sticky),
            .collision_count  (cnt)
        );

        logic [W-1:0] m_or   [LN_L];
        logic         m_coll [LN_L];
        logic         m_sticky;
        int unsigned  m_cnt;
        string        pfx;

        // Advance model and DUT by one clock edge, then compare every output.
        task automatic cyc();
            logic [W-1:0] f;
            logic [W-1:0] wd;
            int           drv;
            f   = '0;
            drv = 0;
            for (int i = 0; i < int'(LN_N); i++) begin
                wd = ehx[i*W +: W];
                if (mask[i] && wd != '0) begin
                    f   = f | wd;
                    drv = drv + 1;
                end
            end
            if (rst) begin
                m_sticky = 1'b0;
                m_cnt    = 0;
            end else if (clr) begin
                m_sticky = m_coll[LN_L-1];
                m_cnt    = m_coll[LN_L-1] ? 1 : 0;
            end else if (m_coll[LN_L-1]) begin
                m_sticky = 1'b1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            if (rst) begin
                for (int i = 0; i < int'(LN_L); i++) begin
                    m_or[i]   = '0;
                    m_coll[i] = 1'b0;
                end
            end else begin
                for (int i = int'(LN_L) - 1; i > 0; i--) begin
                    m_or[i]   = m_or[i-1];
                    m_coll[i] = m_coll[i-1];
                end
                m_or[0]   = f;
                m_coll[0] = (drv >= 2);
            end
            @(posedge clk);
            #1;
            check({pfx, "_okEH"},   128'(eh),     128'(m_or[LN_L-1]));
            check({pfx, "_coll"},   128'(coll),   128'(m_coll[LN_L-1]));
            check({pfx, "_sticky"}, 128'(sticky), 128'(m_sticky));
            check({pfx, "_count"},  128'(cnt),    128'(m_cnt));
        endtask

        initial begin
            logic [W-1:0] wa;
            logic [W-1:0] wb;
            int           mode;
            pfx = $sformatf("n%0d", LN_N);
            for (int i = 0; i < int'(LN_L); i++) begin
                m_or[i]   = '0;
                m_coll[i] = 1'b0;
            end
            m_sticky = 1'b0;
            m_cnt    = 0;
            rst  = 1'b1;
            clr  = 1'b0;
            ehx  = '0;
            mask = '1;
            cyc();
            cyc();
            check({pfx, "_rst_okEH"}, 128'(eh), 128'(0));
            rst = 1'b0;

            // Single driver carries through untouched after the pipeline latency.
            ehx[(LN_N/2)*W +: W] = 65'h1_0000_00AB;
            repeat (LN_L) cyc();
            check({pfx, "_single_ab"}, 128'(eh), 128'(65'h1_0000_00AB));
            ehx = '0;
            repeat (LN_L + 1) cyc();

            // Two drivers in one cycle, then the same with the second one masked off.
            wa = 65'h0_0000_1234_0000_0001;
            wb = 65'h1_8000_0000_0000_0100;
            for (int pass = 0; pass < 2; pass++) begin
                ehx = '0;
                ehx[0 +: W]            = wa;
                ehx[(LN_N-1)*W +: W]   = wb;
                mask[LN_N-1]           = (pass == 0);
                cyc();
                ehx  = '0;
                mask = '1;
                repeat (LN_L + 2) cyc();
            end
            clr = 1'b1;
            cyc();
            clr = 1'b0;

            // Random traffic with random masks, clears and mid-stream resets.
            for (int t = 0; t < 400; t++) begin
                mode = int'($urandom_range(0, 3));
                ehx  = '0;
                if (mode == 0) begin
                    rnd_word(wa);
                    ehx[$urandom_range(0, LN_N-1)*W +: W] = wa;
                end else if (mode == 1) begin
                    for (int i = 0; i < int'(LN_N); i++) begin
                        rnd_word(wa);
                        if ($urandom_range(0, 1) == 1) ehx[i*W +: W] = wa;
                    end
                end else if (mode == 3) begin
                    rnd_word(wa);
                    rnd_word(wb);
                    ehx[$urandom_range(0, LN_N-1)*W +: W] = wa;
                    ehx[$urandom_range(0, LN_N-1)*W +: W] = wb;
                end
                for (int i = 0; i < int'(LN_N); i++) mask[i] = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 15) == 0);
                rst = ($urandom_range(0, 39) == 0);
                cyc();
            end
            clr  = 1'b0;
            rst  = 1'b0;
            mask = '1;

            // Reset in the middle of single-driver traffic, then resume.
            for (int t = 0; t < 30; t++) begin
                ehx = '0;
                rnd_word(wa);
                ehx[$urandom_range(0, LN_N-1)*W +: W] = wa;
                rst = (t == 10);
                cyc();
                if (t == 10) begin
                    check({pfx, "_midrst_okEH"},  128'(eh),  128'(0));
                    check({pfx, "_midrst_count"}, 128'(cnt), 128'(0));
                end
            end
            rst = 1'b0;

            // Continuous contention drives the counter into saturation.
            ehx = '0;
            ehx[0 +: W]          = 65'h0_0000_0000_0000_0011;
            ehx[(LN_N-1)*W +: W] = 65'h0_0000_0000_0000_0100;
            repeat (70000) cyc();
            check({pfx, "_sat_count"}, 128'(cnt), (LN_N > 1) ? 128'hFFFF : 128'h0);
            clr = 1'b1;
            cyc();
            clr = 1'b0;
            check({pfx, "_clr_count"}, 128'(cnt), (LN_N > 1) ? 128'h1 : 128'h0);
            ehx = '0;
            repeat (LN_L + 2) cyc();
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 90000 && !all_done; c++) begin
            @(posedge clk);
            all_done = g_lane[0].done && g_lane[1].done && g_lane[2].done && g_lane[3].done;
        end
        check("lanes_done",
              128'({g_lane[3].done, g_lane[2].done, g_lane[1].done, g_lane[0].done}),
              128'(4'hF));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
